mano_control_sequencer: RTL and testbench

Control unit for the 8-bit Mano basic computer: a sequence counter, a latched opcode decoder and control-word generation that drive the shared bus and the AR/PC/DR/AC/IR/memory load strobes each T-state. It sits beside the datapath in the top level. It consumes IR and AC/DR/E status and emits every register and bus control. Fetch, indirect-address resolution, memory-reference and register-reference execution are all sequenced here.

---
 rtl/mano_control_sequencer.sv | 166 ++++++++++++++++
 tb/tb_mano_control_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mano_control_sequencer.sv
// Mano basic computer control unit: T-state sequence counter, latched opcode decode, per-state bus/strobe control word.
// Build with MANO_SINGLE_STEP_EN to add the STEP port and one-instruction-per-pulse gating at T0.
module mano_control_sequencer #(
  parameter int SC_W = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IR,
  input  logic       AC_ZERO,
  input  logic       AC_SIGN,
  input  logic       DR_ZERO,
  input  logic       E_IN,
`ifdef MANO_SINGLE_STEP_EN
  input  logic       STEP,
`endif
  output logic [7:0] Timer,
  output logic [7:0] D,
  output logic       I,
  output logic [2:0] SEL,
  output logic       AR_LD,
  output logic       AR_INR,
  output logic       PC_LD,
  output logic       PC_INR,
  output logic       DR_LD,
  output logic       DR_INR,
  output logic       AC_LD,
  output logic       IR_LD,
  output logic       MEM_WR,
  output logic       E_CLR,
  output logic       E_CMP,
  output logic [2:0] ALU_SEL,
  output logic       HALTED
);

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0, BUS_AR = 3'd1, BUS_PC = 3'd2, BUS_DR = 3'd3,
    BUS_AC   = 3'd4, BUS_IR = 3'd5, BUS_MEM = 3'd7
  } bus_e;

  localparam logic [SC_W-1:0] T0 = SC_W'(0);
  localparam logic [SC_W-1:0] T1 = SC_W'(1);
  localparam logic [SC_W-1:0] T2 = SC_W'(2);
  localparam logic [SC_W-1:0] T3 = SC_W'(3);
  localparam logic [SC_W-1:0] T4 = SC_W'(4);
  localparam logic [SC_W-1:0] T5 = SC_W'(5);
  localparam logic [SC_W-1:0] T6 = SC_W'(6);

  logic [SC_W-1:0] sc_q, sc_d;
  logic [7:0]      d_q;
  logic            i_q, halted_q;
  logic            sc_clr, sc_hold, halt_set, go;
  bus_e            bus;

`ifdef MANO_SINGLE_STEP_EN
  // armed only after STEP has been seen low, so a held STEP runs one instruction
  logic step_armed_q;
  assign go = STEP & step_armed_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              step_armed_q <= 1'b0;
    else if (!STEP)                       step_armed_q <= 1'b1;
    else if (go && sc_q == T0 && !halted_q) step_armed_q <= 1'b0;
  end
`else
  assign go = 1'b1;
`endif

  always_comb begin
    bus      = BUS_NONE;
    ALU_SEL  = 3'd0;
    AR_LD    = 1'b0;
    AR_INR   = 1'b0;
    PC_LD    = 1'b0;
    PC_INR   = 1'b0;
    DR_LD    = 1'b0;
    DR_INR   = 1'b0;
    AC_LD    = 1'b0;
    IR_LD    = 1'b0;
    MEM_WR   = 1'b0;
    E_CLR    = 1'b0;
    E_CMP    = 1'b0;
    sc_clr   = 1'b0;
    sc_hold  = 1'b0;
    halt_set = 1'b0;
    if (!RST && !halted_q) begin
      case (sc_q)
        T0: if (go) begin bus = BUS_PC; AR_LD = 1'b1; end
            else sc_hold = 1'b1;
        T1: begin bus = BUS_MEM; IR_LD = 1'b1; PC_INR = 1'b1; end
        T2: begin bus = BUS_IR; AR_LD = 1'b1; end
        T3: begin
          if (d_q[7]) begin
            sc_clr = 1'b1;
            if (!i_q) begin
              case (IR[3:0])
                4'd0:  AC_LD = 1'b1;
                4'd1:  E_CLR = 1'b1;
                4'd2:  begin AC_LD = 1'b1; ALU_SEL = 3'd4; end
                4'd3:  E_CMP = 1'b1;
                4'd4:  begin AC_LD = 1'b1; ALU_SEL = 3'd5; end
                4'd5:  begin AC_LD = 1'b1; ALU_SEL = 3'd6; end
                4'd6:  begin AC_LD = 1'b1; ALU_SEL = 3'd7; end
                4'd7:  PC_INR = ~AC_SIGN;
                4'd8:  PC_INR = AC_SIGN;
                4'd9:  PC_INR = AC_ZERO;
                4'd10: PC_INR = ~E_IN;
                4'd15: halt_set = 1'b1;
                default: ;
              endcase
            end
          end else if (i_q) begin
            bus = BUS_MEM; AR_LD = 1'b1;
          end
        end
        T4: begin
          if (d_q[0] | d_q[1] | d_q[2] | d_q[6]) begin bus = BUS_MEM; DR_LD = 1'b1; end
          if (d_q[3]) begin bus = BUS_AC; MEM_WR = 1'b1; sc_clr = 1'b1; end
          if (d_q[4]) begin bus = BUS_AR; PC_LD = 1'b1; sc_clr = 1'b1; end
          if (d_q[5]) begin bus = BUS_PC; MEM_WR = 1'b1; AR_INR = 1'b1; end
        end
        T5: begin
          if (d_q[0] | d_q[1] | d_q[2]) begin
            AC_LD   = 1'b1;
            ALU_SEL = d_q[0] ? 3'd1 : (d_q[1] ? 3'd2 : 3'd3);
            sc_clr  = 1'b1;
          end
          if (d_q[5]) begin bus = BUS_AR; PC_LD = 1'b1; sc_clr = 1'b1; end
          if (d_q[6]) DR_INR = 1'b1;
        end
        T6: begin
          if (d_q[6]) begin bus = BUS_DR; MEM_WR = 1'b1; PC_INR = DR_ZERO; end
          sc_clr = 1'b1;
        end
        default: sc_clr = 1'b1;
      endcase
    end
    SEL = bus;

    if (halted_q)                  sc_d = T0;
    else if (sc_hold)              sc_d = sc_q;
    else if (sc_clr || sc_q >= T6) sc_d = T0;
    else                           sc_d = sc_q + SC_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sc_q     <= T0;
      d_q      <= 8'h00;
      i_q      <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      sc_q <= sc_d;
      if (sc_q == T2 && !halted_q) begin
        d_q <= 8'h01 << IR[6:4];
        i_q <= IR[7];
      end
      if (halt_set) halted_q <= 1'b1;
    end
  end

  assign Timer  = 8'h01 << sc_q;
  assign D      = d_q;
  assign I      = i_q;
  assign HALTED = halted_q;

endmodule

// File: tb/tb_mano_control_sequencer.sv
// Directed bench for mano_control_sequencer: per-T-state control words against hand-computed tables.
module tb_mano_control_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] IR;
  logic       AC_ZERO, AC_SIGN, DR_ZERO, E_IN, STEP;
  logic [7:0] Timer, D;
  logic       I, HALTED;
  logic [2:0] SEL, ALU_SEL;
  logic       AR_LD, AR_INR, PC_LD, PC_INR, DR_LD, DR_INR, AC_LD, IR_LD, MEM_WR, E_CLR, E_CMP;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [10:0] B_AR_LD  = 11'h400, B_AR_INR = 11'h200, B_PC_LD  = 11'h100,
                          B_PC_INR = 11'h080, B_DR_LD  = 11'h040, B_DR_INR = 11'h020,
                          B_AC_LD  = 11'h010, B_IR_LD  = 11'h008, B_MEM_WR = 11'h004,
                          B_E_CLR  = 11'h002, B_E_CMP  = 11'h001;

  wire [16:0] ctl = {SEL, ALU_SEL, AR_LD, AR_INR, PC_LD, PC_INR, DR_LD, DR_INR,
                     AC_LD, IR_LD, MEM_WR, E_CLR, E_CMP};

  function automatic logic [16:0] cw(input logic [2:0] s, input logic [2:0] a, input logic [10:0] b);
    return {s, a, b};
  endfunction

  localparam logic [16:0] F0 = {3'd2, 3'd0, 11'h400};
  localparam logic [16:0] F1 = {3'd7, 3'd0, 11'h088};
  localparam logic [16:0] F2 = {3'd5, 3'd0, 11'h400};

  mano_control_sequencer #(.SC_W(3)) dut (
    .CLK(CLK), .RST(RST), .IR(IR), .AC_ZERO(AC_ZERO), .AC_SIGN(AC_SIGN),
    .DR_ZERO(DR_ZERO), .E_IN(E_IN),
`ifdef MANO_SINGLE_STEP_EN
    .STEP(STEP),
`endif
    .Timer(Timer), .D(D), .I(I), .SEL(SEL),
    .AR_LD(AR_LD), .AR_INR(AR_INR), .PC_LD(PC_LD), .PC_INR(PC_INR),
    .DR_LD(DR_LD), .DR_INR(DR_INR), .AC_LD(AC_LD), .IR_LD(IR_LD),
    .MEM_WR(MEM_WR), .E_CLR(E_CLR), .E_CMP(E_CMP), .ALU_SEL(ALU_SEL), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  task automatic test_reset();
    logic [16:0] e [6];
    logic [7:0]  et;
    e = '{F0, F1, F2, 17'h0, cw(3'd7, 3'd0, B_DR_LD), cw(3'd0, 3'd2, B_AC_LD)};
    repeat (2) @(negedge CLK);
    #1;
    n_checks++;
    if ({Timer, D, I, HALTED, ctl} !== {8'h01, 8'h00, 1'b0, 1'b0, 17'h0}) begin
      n_fail++;
      $display("FAIL reset_hold: got T=%h D=%h I=%b H=%b ctl=%h exp T=01 D=00 I=0 H=0 ctl=0", Timer, D, I, HALTED, ctl);
    end
    @(negedge CLK);
    RST = 1'b0;
    IR  = 8'h13;
    for (int k = 0; k < 4; k++) begin
      #1;
      et = 8'h01 << k;
      n_checks++;
      if ({Timer, ctl} !== {et, e[k]}) begin
        n_fail++;
        $display("FAIL reset_pre cyc%0d: got T=%h ctl=%h exp T=%h ctl=%h", k, Timer, ctl, et, e[k]);
      end
      @(negedge CLK);
    end
    RST = 1'b1;
    #1;
    n_checks++;
    if ({Timer, D, I, HALTED, ctl} !== {8'h01, 8'h00, 1'b0, 1'b0, 17'h0}) begin
      n_fail++;
      $display("FAIL reset_midT4: got T=%h D=%h I=%b H=%b ctl=%h exp T=01 D=00 I=0 H=0 ctl=0", Timer, D, I, HALTED, ctl);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      et = 8'h01 << k;
      n_checks++;
      if ({Timer, ctl} !== {et, e[k]}) begin
        n_fail++;
        $display("FAIL reset_resume cyc%0d: got T=%h ctl=%h exp T=%h ctl=%h", k, Timer, ctl, et, e[k]);
      end
      @(negedge CLK);
    end
    #1;
    n_checks++;
    if (Timer !== 8'h01) begin
      n_fail++;
      $display("FAIL reset_resume_len: got T=%h exp T=01", Timer);
    end
  endtask

  task automatic test_mem_ref();
    logic [7:0]  irs [5];
    logic [7:0]  ds  [5];
    int          lens [5];
    logic [16:0] e [5][7];
    logic [7:0]  et;
    irs  = '{8'h13, 8'h93, 8'h55, 8'h35, 8'h44};
    ds   = '{8'h02, 8'h02, 8'h20, 8'h08, 8'h10};
    lens = '{6, 6, 6, 5, 5};
    for (int j = 0; j < 5; j++) begin
      e[j][0] = F0; e[j][1] = F1; e[j][2] = F2;
      for (int k = 3; k < 7; k++) e[j][k] = 17'h0;
    end
    e[0][4] = cw(3'd7, 3'd0, B_DR_LD);  e[0][5] = cw(3'd0, 3'd2, B_AC_LD);
    e[1][3] = cw(3'd7, 3'd0, B_AR_LD);
    e[1][4] = cw(3'd7, 3'd0, B_DR_LD);  e[1][5] = cw(3'd0, 3'd2, B_AC_LD);
    e[2][4] = cw(3'd2, 3'd0, B_MEM_WR | B_AR_INR);
    e[2][5] = cw(3'd1, 3'd0, B_PC_LD);
    e[3][4] = cw(3'd4, 3'd0, B_MEM_WR);
    e[4][4] = cw(3'd1, 3'd0, B_PC_LD);
    for (int j = 0; j < 5; j++) begin
      IR = irs[j];
      for (int k = 0; k < lens[j]; k++) begin
        #1;
        et = 8'h01 << k;
        n_checks++;
        if ({Timer, ctl} !== {et, e[j][k]}) begin
          n_fail++;
          $display("FAIL memref_%h cyc%0d: got T=%h ctl=%h exp T=%h ctl=%h", irs[j], k, Timer, ctl, et, e[j][k]);
        end
        if (k == 3) begin
          n_checks++;
          if ({D, I} !== {ds[j], (j == 1)}) begin
            n_fail++;
            $display("FAIL memref_%h_decode: got D=%h I=%b exp D=%h I=%b", irs[j], D, I, ds[j], (j == 1));
          end
        end
        @(negedge CLK);
      end
      #1;
      n_checks++;
      if (Timer !== 8'h01) begin
        n_fail++;
        $display("FAIL memref_%h_len: got T=%h exp T=01", irs[j], Timer);
      end
    end
  endtask

  task automatic test_isz();
    logic [16:0] e [7];
    logic [7:0]  et;
    IR = 8'h62;
    for (int r = 0; r < 2; r++) begin
      DR_ZERO = (r == 0);
      e = '{F0, F1, F2, 17'h0, cw(3'd7, 3'd0, B_DR_LD), cw(3'd0, 3'd0, B_DR_INR),
            cw(3'd3, 3'd0, (r == 0) ? (B_MEM_WR | B_PC_INR) : B_MEM_WR)};
      for (int k = 0; k < 7; k++) begin
        #1;
        et = 8'h01 << k;
        n_checks++;
        if ({Timer, ctl} !== {et, e[k]}) begin
          n_fail++;
          $display("FAIL isz_drz%0d cyc%0d: got T=%h ctl=%h exp T=%h ctl=%h", (r == 0), k, Timer, ctl, et, e[k]);
        end
        @(negedge CLK);
      end
      #1;
      n_checks++;
      if (Timer !== 8'h01) begin
        n_fail++;
        $display("FAIL isz_len: got T=%h exp T=01", Timer);
      end
    end
    DR_ZERO = 1'b0;
  endtask

  task automatic test_reg_ref();
    logic [7:0]  irs [16];
    logic [2:0]  st  [16];
    logic [16:0] t3  [16];
    logic [16:0] ex;
    logic [7:0]  et;
    irs = '{8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h77,
            8'h78, 8'h78, 8'h79, 8'h7A, 8'h7A, 8'h7B, 8'hF0, 8'h77};
    st  = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
            3'b100, 3'b000, 3'b010, 3'b001, 3'b000, 3'b000, 3'b000, 3'b100};
    t3  = '{cw(3'd0, 3'd0, B_AC_LD), cw(3'd0, 3'd0, B_E_CLR), cw(3'd0, 3'd4, B_AC_LD),
            cw(3'd0, 3'd0, B_E_CMP), cw(3'd0, 3'd5, B_AC_LD), cw(3'd0, 3'd6, B_AC_LD),
            cw(3'd0, 3'd7, B_AC_LD), cw(3'd0, 3'd0, B_PC_INR), cw(3'd0, 3'd0, B_PC_INR),
            17'h0, cw(3'd0, 3'd0, B_PC_INR), 17'h0, cw(3'd0, 3'd0, B_PC_INR),
            17'h0, 17'h0, 17'h0};
    for (int j = 0; j < 16; j++) begin
      IR = irs[j];
      {AC_SIGN, AC_ZERO, E_IN} = st[j];
      for (int k = 0; k < 4; k++) begin
        #1;
        et = 8'h01 << k;
        ex = (k == 0) ? F0 : (k == 1) ? F1 : (k == 2) ? F2 : t3[j];
        n_checks++;
        if ({Timer, ctl} !== {et, ex}) begin
          n_fail++;
          $display("FAIL regref_%0d_%h cyc%0d: got T=%h ctl=%h exp T=%h ctl=%h", j, irs[j], k, Timer, ctl, et, ex);
        end
        if (k == 3) begin
          n_checks++;
          if ({D, I} !== {8'h80, (j == 14)}) begin
            n_fail++;
            $display("FAIL regref_%0d_decode: got D=%h I=%b exp D=80 I=%b", j, D, I, (j == 14));
          end
        end
        @(negedge CLK);
      end
      #1;
      n_checks++;
      if ({Timer, HALTED} !== {8'h01, 1'b0}) begin
        n_fail++;
        $display("FAIL regref_%0d_len: got T=%h H=%b exp T=01 H=0", j, Timer, HALTED);
      end
    end
    {AC_SIGN, AC_ZERO, E_IN} = 3'b000;
  endtask

  task automatic test_halt();
    logic [16:0] ex;
    logic [7:0]  et;
    IR = 8'h7F;
    for (int k = 0; k < 4; k++) begin
      #1;
      et = 8'h01 << k;
      ex = (k == 0) ? F0 : (k == 1) ? F1 : (k == 2) ? F2 : 17'h0;
      n_checks++;
      if ({Timer, HALTED, ctl} !== {et, 1'b0, ex}) begin
        n_fail++;
        $display("FAIL hlt_fetch cyc%0d: got T=%h H=%b ctl=%h exp T=%h H=0 ctl=%h", k, Timer, HALTED, ctl, et, ex);
      end
      @(negedge CLK);
    end
    IR = 8'h13;
    for (int k = 0; k < 20; k++) begin
      #1;
      n_checks++;
      if ({Timer, HALTED, ctl} !== {8'h01, 1'b1, 17'h0}) begin
        n_fail++;
        $display("FAIL hlt_stuck cyc%0d: got T=%h H=%b ctl=%h exp T=01 H=1 ctl=0", k, Timer, HALTED, ctl);
      end
      @(negedge CLK);
    end
  endtask

  initial begin
    RST = 1'b1; IR = 8'h00; AC_ZERO = 1'b0; AC_SIGN = 1'b0;
    DR_ZERO = 1'b0; E_IN = 1'b0; STEP = 1'b0;
    test_reset();
    test_mem_ref();
    test_isz();
    test_reg_ref();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
